pipe_ctrl: RTL and testbench
============================

// Module: pipe_ctrl
// PURPOSE
//  Pipeline control unit for the Y86-64 5-stage pipeline (F/D/E/M/W).
//  - Owns the F-stage predicted-PC register and selects f_pc.
//  - Generates the stall/bubble controls for every pipeline register.
//  - Runs the processor run-state FSM that freezes the core on halt or fault.
//  - Optionally keeps performance counters.
// PARAMETERS
//  RESET_PC  64'h0  value loaded into the predicted-PC register on reset
//  CNT_W     32     width of the cycle and retired-instruction counters
// PORTS
//  clk        in   1   clock, all state updates on posedge
//  rst        in   1   synchronous reset, active-high
//  D_icode    in   4   icode held in the D register
//  E_icode    in   4   icode held in the E register
//  M_icode    in   4   icode held in the M register
//  W_icode    in   4   icode held in the W register
//  d_srcA     in   4   decode source register A
//  d_srcB     in   4   decode source register B
//  E_dstM     in   4   memory destination register of the E-stage instruction
//  e_Cnd      in   1   branch condition computed in E
//  M_Cnd      in   1   branch condition held in the M register
//  M_valA     in   64  fall-through PC carried by the jXX in M
//  W_valM     in   64  return address read by the ret in W
//  f_predPC   in   64  next-PC prediction from fetch
//  m_stat     in   4   status leaving the M stage
//  W_stat     in   4   status held in the W register
//  f_pc       out  64  PC presented to fetch
//  F_stall    out  1   hold the F register
//  D_stall    out  1   hold the D register
//  D_bubble   out  1   load a nop into D
//  E_bubble   out  1   load a nop into E
//  M_bubble   out  1   load a nop into M
//  W_stall    out  1   hold the W register
//  set_cc     out  1   enable condition-code update in E
//  cpu_stat   out  4   latched processor status
//  halted     out  1   core frozen
//  cycle_cnt  out  CNT_W  cycles spent in RUN or DRAIN
//  instr_cnt  out  CNT_W  instructions retired
// BEHAVIOUR
//  Encodings
//  - Status codes (one-hot): AOK=0001, HLT=0010, ADR=0100, INS=1000.
//  - icodes: NOP=1, MRMOVQ=5, OPQ=6, JXX=7, RET=9, POPQ=11.
//  - Register RNONE=15.
//  Hazard terms (combinational)
//  - lu (load/use) = E_icode in {5,11} && E_dstM!=15 && E_dstM in {d_srcA,d_srcB}.
//  - rt (ret in flight) = RET present in any of D, E, M.
//  - mp (mispredict) = E_icode==JXX && !e_Cnd.
//  - exM = m_stat!=AOK.
//  - exW = W_stat!=AOK.
//  Stage controls
//  - F_stall = lu | rt.
//  - D_stall = lu.
//  - D_bubble = mp | (rt & !lu).
//  - E_bubble = mp | lu.
//  - M_bubble = exM | exW.
//  - W_stall = exW.
//  - set_cc = E_icode==OPQ & !exM & !exW.
//  PC select
//  - If M_icode==JXX & !M_Cnd: f_pc = M_valA.
//  - Else if W_icode==RET: f_pc = W_valM.
//  - Else: f_pc = predPC.
//  - predPC <= f_predPC on posedge when !F_stall and state is RUN.
//  Run-state FSM (2-bit)
//  - RUN -> DRAIN on exM.
//  - RUN or DRAIN -> HALT when exW and W_stat==HLT.
//  - RUN or DRAIN -> FAULT when exW and W_stat is any other non-AOK value.
//  - HALT and FAULT are absorbing; only rst leaves them.
//  - On entry to HALT/FAULT: cpu_stat latches W_stat and halted=1.
//  - While halted: all six stall/bubble outputs are forced to 1, set_cc=0, predPC frozen.
//  Counters
//  - cycle_cnt increments every cycle in RUN or DRAIN.
//  - instr_cnt increments when W_icode!=NOP and W_stat==AOK.
//  - Both counters wrap at 2^CNT_W with no saturation.
//  Reset
//  - Synchronous; rst dominates every other input, including mid-drain.
//  - Reset values: state=RUN, predPC=RESET_PC, cpu_stat=AOK, halted=0, both counters=0.
//  - Stall/bubble outputs follow the combinational equations from the first cycle after reset.
// CONFIGURATION
//  PIPE_CTRL_PERF_CNT_EN
//  - Defined: counters are built as specified above.
//  - Undefined: no counter flops are built; cycle_cnt and instr_cnt are tied to 0.
// TESTING
//  1. Load/use: E_icode=5, E_dstM=3, d_srcA=3
//     -> F_stall=1, D_stall=1, E_bubble=1, D_bubble=0.
//  2. Mispredict: E_icode=7, e_Cnd=0
//     -> D_bubble=E_bubble=1.
//     Next cycle M_icode=7, M_Cnd=0, M_valA=0x40 -> f_pc=0x40.
//  3. ret: D_icode=9
//     -> F_stall=1, D_bubble=1 for 3 cycles.
//     Then W_icode=9, W_valM=0x100 -> f_pc=0x100.
//  4. Halt: m_stat=HLT
//     -> M_bubble=1 and state=DRAIN.
//     Next cycle W_stat=HLT -> halted=1, cpu_stat=0010, W_stall=1, cycle_cnt frozen.
//  5. Fault and reset: W_stat=ADR -> cpu_stat=0100.
//     Then rst=1 for 1 cycle -> halted=0, f_pc=RESET_PC, counters=0.

Source files
------------

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl
// Description : Pipeline control unit for the Y86-64 5-stage pipeline.
//               - Holds the F-stage predicted-PC register and selects f_pc
//                 (jXX mispredict repair > ret return address > prediction).
//               - Produces stall/bubble controls for the F/D/E/M/W registers
//                 from load/use, ret-in-flight, mispredict and exception terms.
//               - Run-state FSM (RUN/DRAIN/HALT/FAULT) that freezes the core
//                 once a halt or fault status reaches W.
//               - Optional cycle / retired-instruction counters.
// Ports       : clk, rst (sync, active-high)
//               D/E/M/W_icode, d_srcA, d_srcB, E_dstM, e_Cnd, M_Cnd,
//               M_valA, W_valM, f_predPC, m_stat, W_stat      -> inputs
//               f_pc, F_stall, D_stall, D_bubble, E_bubble, M_bubble,
//               W_stall, set_cc, cpu_stat, halted, cycle_cnt,
//               instr_cnt                                      -> outputs
// Config      : `define PIPE_CTRL_PERF_CNT_EN builds the counters; when
//               undefined cycle_cnt and instr_cnt are tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        D_icode,
    input  logic [3:0]        E_icode,
    input  logic [3:0]        M_icode,
    input  logic [3:0]        W_icode,
    input  logic [3:0]        d_srcA,
    input  logic [3:0]        d_srcB,
    input  logic [3:0]        E_dstM,
    input  logic              e_Cnd,
    input  logic              M_Cnd,
    input  logic [63:0]       M_valA,
    input  logic [63:0]       W_valM,
    input  logic [63:0]       f_predPC,
    input  logic [3:0]        m_stat,
    input  logic [3:0]        W_stat,
    output logic [63:0]       f_pc,
    output logic              F_stall,
    output logic              D_stall,
    output logic              D_bubble,
    output logic              E_bubble,
    output logic              M_bubble,
    output logic              W_stall,
    output logic              set_cc,
    output logic [3:0]        cpu_stat,
    output logic              halted,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  instr_cnt
);

    localparam logic [3:0] c_stat_aok = 4'b0001;
    localparam logic [3:0] c_stat_hlt = 4'b0010;
    localparam logic [3:0] c_i_mrmovq = 4'd5;
    localparam logic [3:0] c_i_opq    = 4'd6;
    localparam logic [3:0] c_i_jxx    = 4'd7;
    localparam logic [3:0] c_i_ret    = 4'd9;
    localparam logic [3:0] c_i_popq   = 4'd11;
    localparam logic [3:0] c_rnone    = 4'd15;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] pred_pc_q, pred_pc_d;
    logic [3:0]  cpu_stat_q, cpu_stat_d;
    logic        halted_q, halted_d;

    logic w_lu, w_rt, w_mp, w_ex_m, w_ex_w, w_running;

    // Hazard terms
    always_comb begin
        w_lu = ((E_icode == c_i_mrmovq) || (E_icode == c_i_popq)) &&
               (E_dstM != c_rnone) &&
               ((E_dstM == d_srcA) || (E_dstM == d_srcB));
        w_rt = (D_icode == c_i_ret) || (E_icode == c_i_ret) || (M_icode == c_i_ret);
        w_mp = (E_icode == c_i_jxx) && !e_Cnd;
        w_ex_m = (m_stat != c_stat_aok);
        w_ex_w = (W_stat != c_stat_aok);
        w_running = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    end

    // Stage controls; a frozen core holds every register and keeps CCs intact
    always_comb begin
        F_stall  = w_lu | w_rt;
        D_stall  = w_lu;
        D_bubble = w_mp | (w_rt & ~w_lu);
        E_bubble = w_mp | w_lu;
        M_bubble = w_ex_m | w_ex_w;
        W_stall  = w_ex_w;
        set_cc   = (E_icode == c_i_opq) & ~w_ex_m & ~w_ex_w;
        if (halted_q) begin
            F_stall  = 1'b1;
            D_stall  = 1'b1;
            D_bubble = 1'b1;
            E_bubble = 1'b1;
            M_bubble = 1'b1;
            W_stall  = 1'b1;
            set_cc   = 1'b0;
        end
    end

    // PC select: a not-taken jXX in M repairs the prediction before a ret in W
    always_comb begin
        if ((M_icode == c_i_jxx) && !M_Cnd) begin
            f_pc = M_valA;
        end else if (W_icode == c_i_ret) begin
            f_pc = W_valM;
        end else begin
            f_pc = pred_pc_q;
        end
    end

    // Next-state logic for the run FSM and the registers it gates
    always_comb begin
        state_d    = state_q;
        cpu_stat_d = cpu_stat_q;
        halted_d   = halted_q;
        pred_pc_d  = pred_pc_q;

        // Only fetch in RUN advances the prediction; DRAIN fetches nothing new
        if ((state_q == ST_RUN) && !(w_lu | w_rt)) begin
            pred_pc_d = f_predPC;
        end

        if (w_running) begin
            if (w_ex_w) begin
                state_d    = (W_stat == c_stat_hlt) ? ST_HALT : ST_FAULT;
                cpu_stat_d = W_stat;
                halted_d   = 1'b1;
            end else if (w_ex_m && (state_q == ST_RUN)) begin
                state_d = ST_DRAIN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            pred_pc_q  <= RESET_PC;
            cpu_stat_q <= c_stat_aok;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pred_pc_q  <= pred_pc_d;
            cpu_stat_q <= cpu_stat_d;
            halted_q   <= halted_d;
        end
    end

    assign cpu_stat = cpu_stat_q;
    assign halted   = halted_q;

`ifdef PIPE_CTRL_PERF_CNT_EN
    localparam logic [3:0] c_i_nop = 4'd1;

    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;

    // Both counters wrap naturally at 2^CNT_W
    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        instr_cnt_d = instr_cnt_q;
        if (w_running) begin
            cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
        end
        if ((W_icode != c_i_nop) && (W_stat == c_stat_aok)) begin
            instr_cnt_d = instr_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;
`else
    assign cycle_cnt = '0;
    assign instr_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_ctrl
// Description : Directed self-checking bench for pipe_ctrl. RESET_PC is
//               overridden to 0x1000 and CNT_W to 4 so counter wrap is
//               reachable in a few cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

    localparam logic [63:0] C_RESET_PC = 64'h1000;
    localparam int          C_CNT_W    = 4;
`ifdef PIPE_CTRL_PERF_CNT_EN
    localparam bit c_perf = 1'b1;
`else
    localparam bit c_perf = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic [3:0]         D_icode, E_icode, M_icode, W_icode;
    logic [3:0]         d_srcA, d_srcB, E_dstM;
    logic               e_Cnd, M_Cnd;
    logic [63:0]        M_valA, W_valM, f_predPC;
    logic [3:0]         m_stat, W_stat;
    logic [63:0]        f_pc;
    logic               F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall;
    logic               set_cc;
    logic [3:0]         cpu_stat;
    logic               halted;
    logic [C_CNT_W-1:0] cycle_cnt, instr_cnt;
    logic [5:0]         ctl;

    int n_checks = 0;
    int n_fail   = 0;

    assign ctl = {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall};

    pipe_ctrl #(
        .RESET_PC (C_RESET_PC),
        .CNT_W    (C_CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .D_icode   (D_icode),
        .E_icode   (E_icode),
        .M_icode   (M_icode),
        .W_icode   (W_icode),
        .d_srcA    (d_srcA),
        .d_srcB    (d_srcB),
        .E_dstM    (E_dstM),
        .e_Cnd     (e_Cnd),
        .M_Cnd     (M_Cnd),
        .M_valA    (M_valA),
        .W_valM    (W_valM),
        .f_predPC  (f_predPC),
        .m_stat    (m_stat),
        .W_stat    (W_stat),
        .f_pc      (f_pc),
        .F_stall   (F_stall),
        .D_stall   (D_stall),
        .D_bubble  (D_bubble),
        .E_bubble  (E_bubble),
        .M_bubble  (M_bubble),
        .W_stall   (W_stall),
        .set_cc    (set_cc),
        .cpu_stat  (cpu_stat),
        .halted    (halted),
        .cycle_cnt (cycle_cnt),
        .instr_cnt (instr_cnt)
    );

    always #5 clk = ~clk;

    // Pipeline full of nops, everything AOK
    task automatic idle();
        D_icode = 4'd1; E_icode = 4'd1; M_icode = 4'd1; W_icode = 4'd1;
        d_srcA = 4'd15; d_srcB = 4'd15; E_dstM = 4'd15;
        e_Cnd = 1'b1; M_Cnd = 1'b1;
        M_valA = 64'h0; W_valM = 64'h0; f_predPC = 64'h2000;
        m_stat = 4'b0001; W_stat = 4'b0001;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        do_reset();
        #1;
        n_checks++; if (f_pc !== 64'h1000) begin n_fail++; $display("FAIL reset_f_pc got=%h exp=%h", f_pc, 64'h1000); end
        n_checks++; if (ctl !== 6'b000000) begin n_fail++; $display("FAIL reset_ctl got=%b exp=%b", ctl, 6'b000000); end
        n_checks++; if (set_cc !== 1'b0) begin n_fail++; $display("FAIL reset_set_cc got=%b exp=0", set_cc); end
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got=%b exp=0", halted); end
        n_checks++; if (cpu_stat !== 4'b0001) begin n_fail++; $display("FAIL reset_cpu_stat got=%b exp=0001", cpu_stat); end
        n_checks++; if (cycle_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_cycle_cnt got=%0d exp=0", cycle_cnt); end
        n_checks++; if (instr_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_instr_cnt got=%0d exp=0", instr_cnt); end
    endtask

    task automatic test_load_use();
        step();
        idle();
        E_icode = 4'd5; E_dstM = 4'd3; d_srcA = 4'd3;
        #1;
        n_checks++; if (ctl !== 6'b110100) begin n_fail++; $display("FAIL lu_mrmovq_srcA got=%b exp=%b", ctl, 6'b110100); end
        E_icode = 4'd11; d_srcA = 4'd15; d_srcB = 4'd3;
        #1;
        n_checks++; if (ctl !== 6'b110100) begin n_fail++; $display("FAIL lu_popq_srcB got=%b exp=%b", ctl, 6'b110100); end
        E_icode = 4'd5; E_dstM = 4'd15; d_srcB = 4'd15;
        #1;
        n_checks++; if (ctl !== 6'b000000) begin n_fail++; $display("FAIL lu_rnone got=%b exp=%b", ctl, 6'b000000); end
        E_icode = 4'd6; E_dstM = 4'd3; d_srcA = 4'd3;
        #1;
        n_checks++; if (ctl !== 6'b000000) begin n_fail++; $display("FAIL lu_opq_no_stall got=%b exp=%b", ctl, 6'b000000); end
        n_checks++; if (set_cc !== 1'b1) begin n_fail++; $display("FAIL opq_set_cc got=%b exp=1", set_cc); end
        idle();
    endtask

    task automatic test_mispredict();
        step();
        idle();
        E_icode = 4'd7; e_Cnd = 1'b0;
        #1;
        n_checks++; if (ctl !== 6'b001100) begin n_fail++; $display("FAIL mp_bubbles got=%b exp=%b", ctl, 6'b001100); end
        e_Cnd = 1'b1;
        #1;
        n_checks++; if (ctl !== 6'b000000) begin n_fail++; $display("FAIL jxx_taken got=%b exp=%b", ctl, 6'b000000); end
        step();
        idle();
        M_icode = 4'd7; M_Cnd = 1'b0; M_valA = 64'h40;
        #1;
        n_checks++; if (f_pc !== 64'h40) begin n_fail++; $display("FAIL mp_f_pc got=%h exp=%h", f_pc, 64'h40); end
        M_Cnd = 1'b1;
        #1;
        n_checks++; if (f_pc !== 64'h2000) begin n_fail++; $display("FAIL taken_f_pc got=%h exp=%h", f_pc, 64'h2000); end
        M_Cnd = 1'b0; W_icode = 4'd9; W_valM = 64'h100;
        #1;
        n_checks++; if (f_pc !== 64'h40) begin n_fail++; $display("FAIL mp_over_ret got=%h exp=%h", f_pc, 64'h40); end
        idle();
    endtask

    task automatic test_ret();
        step();
        idle();
        f_predPC = 64'h3000; D_icode = 4'd9;
        #1;
        n_checks++; if (ctl !== 6'b101000) begin n_fail++; $display("FAIL ret_in_D got=%b exp=%b", ctl, 6'b101000); end
        step();
        D_icode = 4'd1; E_icode = 4'd9;
        #1;
        n_checks++; if (ctl !== 6'b101000) begin n_fail++; $display("FAIL ret_in_E got=%b exp=%b", ctl, 6'b101000); end
        step();
        E_icode = 4'd1; M_icode = 4'd9;
        #1;
        n_checks++; if (ctl !== 6'b101000) begin n_fail++; $display("FAIL ret_in_M got=%b exp=%b", ctl, 6'b101000); end
        n_checks++; if (f_pc !== 64'h2000) begin n_fail++; $display("FAIL ret_pc_held got=%h exp=%h", f_pc, 64'h2000); end
        step();
        M_icode = 4'd1; W_icode = 4'd9; W_valM = 64'h100;
        #1;
        n_checks++; if (f_pc !== 64'h100) begin n_fail++; $display("FAIL ret_f_pc got=%h exp=%h", f_pc, 64'h100); end
        n_checks++; if (ctl !== 6'b000000) begin n_fail++; $display("FAIL ret_in_W_ctl got=%b exp=%b", ctl, 6'b000000); end
        D_icode = 4'd9; E_icode = 4'd5; E_dstM = 4'd3; d_srcA = 4'd3;
        #1;
        n_checks++; if (ctl !== 6'b110100) begin n_fail++; $display("FAIL ret_with_lu got=%b exp=%b", ctl, 6'b110100); end
        idle();
    endtask

    task automatic test_halt();
        idle();
        do_reset();
        f_predPC = 64'h5000; m_stat = 4'b0010; E_icode = 4'd6;
        #1;
        n_checks++; if (ctl !== 6'b000010) begin n_fail++; $display("FAIL hlt_in_M_ctl got=%b exp=%b", ctl, 6'b000010); end
        n_checks++; if (set_cc !== 1'b0) begin n_fail++; $display("FAIL hlt_in_M_set_cc got=%b exp=0", set_cc); end
        step();
        idle();
        f_predPC = 64'h6000; W_stat = 4'b0010;
        #1;
        n_checks++; if (ctl !== 6'b000011) begin n_fail++; $display("FAIL hlt_in_W_ctl got=%b exp=%b", ctl, 6'b000011); end
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL drain_halted got=%b exp=0", halted); end
        n_checks++; if (f_pc !== 64'h5000) begin n_fail++; $display("FAIL drain_f_pc got=%h exp=%h", f_pc, 64'h5000); end
        step();
        idle();
        E_icode = 4'd6;
        #1;
        n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_halted got=%b exp=1", halted); end
        n_checks++; if (cpu_stat !== 4'b0010) begin n_fail++; $display("FAIL halt_cpu_stat got=%b exp=0010", cpu_stat); end
        n_checks++; if (ctl !== 6'b111111) begin n_fail++; $display("FAIL halt_ctl got=%b exp=%b", ctl, 6'b111111); end
        n_checks++; if (set_cc !== 1'b0) begin n_fail++; $display("FAIL halt_set_cc got=%b exp=0", set_cc); end
        step();
        step();
        n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_absorbing got=%b exp=1", halted); end
        n_checks++; if (cpu_stat !== 4'b0010) begin n_fail++; $display("FAIL halt_cpu_stat_held got=%b exp=0010", cpu_stat); end
        n_checks++; if (f_pc !== 64'h5000) begin n_fail++; $display("FAIL halt_f_pc_frozen got=%h exp=%h", f_pc, 64'h5000); end
        n_checks++; if (cycle_cnt !== (c_perf ? 4'd2 : 4'd0)) begin n_fail++; $display("FAIL halt_cycle_cnt got=%0d exp=%0d", cycle_cnt, c_perf ? 2 : 0); end
        n_checks++; if (instr_cnt !== 4'd0) begin n_fail++; $display("FAIL halt_instr_cnt got=%0d exp=0", instr_cnt); end
        idle();
    endtask

    task automatic test_fault_reset();
        idle();
        do_reset();
        W_stat = 4'b0100;
        #1;
        n_checks++; if (ctl !== 6'b000011) begin n_fail++; $display("FAIL adr_in_W_ctl got=%b exp=%b", ctl, 6'b000011); end
        step();
        n_checks++; if (cpu_stat !== 4'b0100) begin n_fail++; $display("FAIL adr_cpu_stat got=%b exp=0100", cpu_stat); end
        n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL adr_halted got=%b exp=1", halted); end
        m_stat = 4'b0100;
        do_reset();
        idle();
        #1;
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL rst_halted got=%b exp=0", halted); end
        n_checks++; if (cpu_stat !== 4'b0001) begin n_fail++; $display("FAIL rst_cpu_stat got=%b exp=0001", cpu_stat); end
        n_checks++; if (f_pc !== 64'h1000) begin n_fail++; $display("FAIL rst_f_pc got=%h exp=%h", f_pc, 64'h1000); end
        n_checks++; if (ctl !== 6'b000000) begin n_fail++; $display("FAIL rst_ctl got=%b exp=%b", ctl, 6'b000000); end
        n_checks++; if (cycle_cnt !== 4'd0) begin n_fail++; $display("FAIL rst_cycle_cnt got=%0d exp=0", cycle_cnt); end
        W_stat = 4'b1000;
        step();
        n_checks++; if (cpu_stat !== 4'b1000) begin n_fail++; $display("FAIL ins_cpu_stat got=%b exp=1000", cpu_stat); end
        // Reset arriving while draining must return the FSM to RUN
        idle();
        do_reset();
        m_stat = 4'b0010;
        step();
        do_reset();
        idle();
        f_predPC = 64'h7000;
        step();
        n_checks++; if (f_pc !== 64'h7000) begin n_fail++; $display("FAIL rst_mid_drain_f_pc got=%h exp=%h", f_pc, 64'h7000); end
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL rst_mid_drain_halted got=%b exp=0", halted); end
        idle();
    endtask

    task automatic test_counters();
        idle();
        do_reset();
        W_icode = 4'd6;
        repeat (3) step();
        W_icode = 4'd1;
        step();
        n_checks++; if (cycle_cnt !== (c_perf ? 4'd4 : 4'd0)) begin n_fail++; $display("FAIL cnt_cycle got=%0d exp=%0d", cycle_cnt, c_perf ? 4 : 0); end
        n_checks++; if (instr_cnt !== (c_perf ? 4'd3 : 4'd0)) begin n_fail++; $display("FAIL cnt_instr got=%0d exp=%0d", instr_cnt, c_perf ? 3 : 0); end
        W_icode = 4'd6;
        repeat (13) step();
        n_checks++; if (cycle_cnt !== (c_perf ? 4'd1 : 4'd0)) begin n_fail++; $display("FAIL cnt_cycle_wrap got=%0d exp=%0d", cycle_cnt, c_perf ? 1 : 0); end
        n_checks++; if (instr_cnt !== 4'd0) begin n_fail++; $display("FAIL cnt_instr_wrap got=%0d exp=0", instr_cnt); end
        W_stat = 4'b0100;
        step();
        n_checks++; if (instr_cnt !== 4'd0) begin n_fail++; $display("FAIL cnt_instr_non_aok got=%0d exp=0", instr_cnt); end
        n_checks++; if (cycle_cnt !== (c_perf ? 4'd2 : 4'd0)) begin n_fail++; $display("FAIL cnt_cycle_fault got=%0d exp=%0d", cycle_cnt, c_perf ? 2 : 0); end
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_load_use();
        test_mispredict();
        test_ret();
        test_halt();
        test_fault_reset();
        test_counters();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
